// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - opcode/handshake inputs and datapath strobes of the multi-cycle controller
interface multicycle_control_if #(
  parameter int OP_W  = 6,
  parameter int CNT_W = 32
);
  logic [OP_W-1:0]  opcode;
  logic             stall;
  logic             mem_ready;
  logic             PCWrite;
  logic             IRWrite;
  logic             RegDst;
  logic             ALUSrc;
  logic             MemtoReg;
  logic             RegWrite;
  logic             MemRead;
  logic             MemWrite;
  logic [1:0]       ALUOp;
  logic             illegal;
  logic             mem_abort;
  logic             retire;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, stall, mem_ready,
    output PCWrite, IRWrite, RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
           ALUOp, illegal, mem_abort, retire, retired
  );

  modport slave (
    output opcode, stall, mem_ready,
    input  PCWrite, IRWrite, RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
           ALUOp, illegal, mem_abort, retire, retired
  );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - FETCH/DECODE/EXEC/MEM/WB sequencer with memory timeout and retire counter
module multicycle_control #(
  parameter int              OP_W      = 6,
  parameter logic [OP_W-1:0] OPC_RTYPE = 6'b000100,
  parameter logic [OP_W-1:0] OPC_ADDI  = 6'b001100,
  parameter logic [OP_W-1:0] OPC_SUBI  = 6'b001101,
  parameter logic [OP_W-1:0] OPC_SW    = 6'b010000,
  parameter logic [OP_W-1:0] OPC_LW    = 6'b010001,
  parameter int              MEM_TO    = 16,
  parameter int              CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);
  localparam logic [2:0] ST_RST    = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;

  localparam logic [2:0] CL_NONE = 3'd0;
  localparam logic [2:0] CL_R    = 3'd1;
  localparam logic [2:0] CL_ADDI = 3'd2;
  localparam logic [2:0] CL_SUBI = 3'd3;
  localparam logic [2:0] CL_SW   = 3'd4;
  localparam logic [2:0] CL_LW   = 3'd5;

  localparam int              TO_W    = (MEM_TO > 1) ? $clog2(MEM_TO) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TO - 1);

  logic [2:0]       state, state_nxt;
  logic [2:0]       cls, cls_dec;
  logic [TO_W-1:0]  to_cnt;
  logic [CNT_W-1:0] retired_q;
  logic             retire_c;

  always_comb begin
    cls_dec = CL_NONE;
    if      (bus.opcode == OPC_RTYPE) cls_dec = CL_R;
    else if (bus.opcode == OPC_ADDI)  cls_dec = CL_ADDI;
    else if (bus.opcode == OPC_SUBI)  cls_dec = CL_SUBI;
    else if (bus.opcode == OPC_SW)    cls_dec = CL_SW;
    else if (bus.opcode == OPC_LW)    cls_dec = CL_LW;
  end

  // mem_ready is tested before the timeout so a late ready still completes the access
  always_comb begin
    state_nxt = state;
    if (!bus.stall) begin
      case (state)
        ST_RST:    state_nxt = ST_FETCH;
        ST_FETCH:  state_nxt = ST_DECODE;
        ST_DECODE: state_nxt = (cls_dec == CL_NONE) ? ST_FETCH : ST_EXEC;
        ST_EXEC:   state_nxt = (cls == CL_SW || cls == CL_LW) ? ST_MEM : ST_WB;
        ST_MEM: begin
          if (bus.mem_ready)         state_nxt = (cls == CL_LW) ? ST_WB : ST_FETCH;
          else if (to_cnt == TO_LAST) state_nxt = ST_FETCH;
        end
        ST_WB:     state_nxt = ST_FETCH;
        default:   state_nxt = ST_RST;
      endcase
    end
  end

  assign retire_c = !bus.stall &&
                    ((state == ST_WB) || (state == ST_MEM && cls == CL_SW && bus.mem_ready));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RST;
      cls       <= CL_NONE;
      to_cnt    <= '0;
      retired_q <= '0;
    end else if (!bus.stall) begin
      state <= state_nxt;
      if (state == ST_DECODE) cls <= cls_dec;
      if (state != ST_MEM)      to_cnt <= '0;
      else if (!bus.mem_ready)  to_cnt <= to_cnt + 1'b1;
      if (retire_c) retired_q <= retired_q + 1'b1;
    end
  end

  assign bus.retired = retired_q;
  assign bus.retire  = retire_c;

  // Moore decode; stall only masks the write strobes and pulses, selects stay put
  always_comb begin
    bus.PCWrite   = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.RegDst    = 1'b0;
    bus.ALUSrc    = 1'b0;
    bus.MemtoReg  = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.ALUOp     = 2'b11;
    bus.illegal   = 1'b0;
    bus.mem_abort = 1'b0;
    case (state)
      ST_FETCH: begin
        bus.PCWrite = 1'b1;
        bus.IRWrite = 1'b1;
        bus.ALUOp   = 2'b00;
      end
      ST_DECODE: bus.illegal = !bus.stall && (cls_dec == CL_NONE);
      ST_EXEC: begin
        bus.ALUSrc = (cls != CL_R);
        if (cls == CL_R)         bus.ALUOp = 2'b10;
        else if (cls == CL_SUBI) bus.ALUOp = 2'b01;
        else                     bus.ALUOp = 2'b00;
      end
      ST_MEM: begin
        bus.ALUOp     = 2'b00;
        bus.MemRead   = (cls == CL_LW);
        bus.MemWrite  = (cls == CL_SW);
        bus.mem_abort = !bus.stall && !bus.mem_ready && (to_cnt == TO_LAST);
      end
      ST_WB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = (cls == CL_R);
        bus.MemtoReg = (cls == CL_LW);
      end
      default: ;
    endcase
    if (bus.stall) begin
      bus.PCWrite  = 1'b0;
      bus.IRWrite  = 1'b0;
      bus.RegWrite = 1'b0;
      bus.MemRead  = 1'b0;
      bus.MemWrite = 1'b0;
    end
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - vector table plus hand sequences for timeout, stall and mid-instruction reset
module tb_multicycle_control;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_if #(.OP_W(6), .CNT_W(32)) bus ();

  multicycle_control #(.MEM_TO(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // {PCWrite,IRWrite,RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,ALUOp[1:0],illegal,mem_abort,retire}
  localparam logic [12:0] E_RST      = 13'b00000000_11_000;
  localparam logic [12:0] E_FETCH    = 13'b11000000_00_000;
  localparam logic [12:0] E_DEC      = 13'b00000000_11_000;
  localparam logic [12:0] E_DEC_ILL  = 13'b00000000_11_100;
  localparam logic [12:0] E_EX_R     = 13'b00000000_10_000;
  localparam logic [12:0] E_EX_ADD   = 13'b00010000_00_000;
  localparam logic [12:0] E_EX_SUB   = 13'b00010000_01_000;
  localparam logic [12:0] E_MEM_LW   = 13'b00000010_00_000;
  localparam logic [12:0] E_MEM_SW   = 13'b00000001_00_000;
  localparam logic [12:0] E_SW_RET   = 13'b00000001_00_001;
  localparam logic [12:0] E_SW_ABORT = 13'b00000001_00_010;
  localparam logic [12:0] E_WB_R     = 13'b00100100_11_001;
  localparam logic [12:0] E_WB_I     = 13'b00000100_11_001;
  localparam logic [12:0] E_WB_LW    = 13'b00001100_11_001;
  localparam logic [12:0] E_WB_STALL = 13'b00000000_11_000;
  localparam logic [12:0] E_MEM_STL  = 13'b00000000_00_000;

  localparam logic [5:0] OP_R   = 6'b000100;
  localparam logic [5:0] OP_ADD = 6'b001100;
  localparam logic [5:0] OP_SUB = 6'b001101;
  localparam logic [5:0] OP_SW  = 6'b010000;
  localparam logic [5:0] OP_LW  = 6'b010001;
  localparam logic [5:0] OP_BAD = 6'b111111;

  typedef struct packed {
    logic [5:0]  op;
    logic        st;
    logic        mr;
    logic [12:0] exp;
    logic [31:0] ret;
  } vec_t;

  vec_t tbl [0:27];
  int total = 0;
  int bad = 0;

  task automatic chk(input logic [12:0] exp, input logic [31:0] r, input string nm);
    logic [12:0] g;
    g = {bus.PCWrite, bus.IRWrite, bus.RegDst, bus.ALUSrc, bus.MemtoReg, bus.RegWrite,
         bus.MemRead, bus.MemWrite, bus.ALUOp, bus.illegal, bus.mem_abort, bus.retire};
    total++;
    if (g !== exp || bus.retired !== r) begin
      bad++;
      $display("FAIL %s: ctrl=%b want=%b retired=%0d want=%0d", nm, g, exp, bus.retired, r);
    end
  endtask

  task automatic cyc(input logic [5:0] op, input logic st, input logic mr,
                     input logic [12:0] exp, input logic [31:0] r, input string nm);
    bus.opcode    = op;
    bus.stall     = st;
    bus.mem_ready = mr;
    @(negedge clk);
    chk(exp, r, nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // R-type with a garbage opcode after DECODE, proving the class latch
    tbl[0]  = '{OP_R,   1'b0, 1'b0, E_RST,     32'd0};
    tbl[1]  = '{OP_R,   1'b0, 1'b0, E_FETCH,   32'd0};
    tbl[2]  = '{OP_R,   1'b0, 1'b0, E_DEC,     32'd0};
    tbl[3]  = '{OP_BAD, 1'b0, 1'b0, E_EX_R,    32'd0};
    tbl[4]  = '{OP_BAD, 1'b0, 1'b0, E_WB_R,    32'd0};
    tbl[5]  = '{OP_ADD, 1'b0, 1'b0, E_FETCH,   32'd1};
    tbl[6]  = '{OP_ADD, 1'b0, 1'b0, E_DEC,     32'd1};
    tbl[7]  = '{OP_ADD, 1'b0, 1'b0, E_EX_ADD,  32'd1};
    tbl[8]  = '{OP_ADD, 1'b0, 1'b0, E_WB_I,    32'd1};
    tbl[9]  = '{OP_SUB, 1'b0, 1'b0, E_FETCH,   32'd2};
    tbl[10] = '{OP_SUB, 1'b0, 1'b0, E_DEC,     32'd2};
    tbl[11] = '{OP_SUB, 1'b0, 1'b0, E_EX_SUB,  32'd2};
    tbl[12] = '{OP_SUB, 1'b0, 1'b0, E_WB_I,    32'd2};
    tbl[13] = '{OP_LW,  1'b0, 1'b0, E_FETCH,   32'd3};
    tbl[14] = '{OP_LW,  1'b0, 1'b0, E_DEC,     32'd3};
    tbl[15] = '{OP_LW,  1'b0, 1'b0, E_EX_ADD,  32'd3};
    tbl[16] = '{OP_LW,  1'b0, 1'b0, E_MEM_LW,  32'd3};
    tbl[17] = '{OP_LW,  1'b0, 1'b0, E_MEM_LW,  32'd3};
    tbl[18] = '{OP_LW,  1'b0, 1'b0, E_MEM_LW,  32'd3};
    tbl[19] = '{OP_LW,  1'b0, 1'b1, E_MEM_LW,  32'd3};
    tbl[20] = '{OP_LW,  1'b0, 1'b0, E_WB_LW,   32'd3};
    tbl[21] = '{OP_SW,  1'b0, 1'b0, E_FETCH,   32'd4};
    tbl[22] = '{OP_SW,  1'b0, 1'b0, E_DEC,     32'd4};
    tbl[23] = '{OP_SW,  1'b0, 1'b0, E_EX_ADD,  32'd4};
    tbl[24] = '{OP_SW,  1'b0, 1'b1, E_SW_RET,  32'd4};
    tbl[25] = '{OP_BAD, 1'b0, 1'b0, E_FETCH,   32'd5};
    tbl[26] = '{OP_BAD, 1'b0, 1'b0, E_DEC_ILL, 32'd5};
    tbl[27] = '{OP_SW,  1'b0, 1'b0, E_FETCH,   32'd5};

    bus.opcode    = 6'd0;
    bus.stall     = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk(E_RST, 32'd0, "in_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 28; i++)
      cyc(tbl[i].op, tbl[i].st, tbl[i].mr, tbl[i].exp, tbl[i].ret, $sformatf("vec%0d", i));

    // sw that never sees mem_ready: 16 MemWrite cycles, abort on the last
    cyc(OP_SW, 1'b0, 1'b0, E_DEC, 32'd5, "to_dec");
    cyc(OP_SW, 1'b0, 1'b0, E_EX_ADD, 32'd5, "to_exec");
    for (int i = 0; i < 15; i++)
      cyc(OP_SW, 1'b0, 1'b0, E_MEM_SW, 32'd5, $sformatf("to_wait%0d", i));
    cyc(OP_SW, 1'b0, 1'b0, E_SW_ABORT, 32'd5, "to_abort");
    cyc(OP_SW, 1'b0, 1'b0, E_FETCH, 32'd5, "to_fetch_no_retire");

    // mem_ready arriving on the timeout cycle completes the store
    cyc(OP_SW, 1'b0, 1'b0, E_DEC, 32'd5, "rw_dec");
    cyc(OP_SW, 1'b0, 1'b0, E_EX_ADD, 32'd5, "rw_exec");
    for (int i = 0; i < 15; i++)
      cyc(OP_SW, 1'b0, 1'b0, E_MEM_SW, 32'd5, $sformatf("rw_wait%0d", i));
    cyc(OP_SW, 1'b0, 1'b1, E_SW_RET, 32'd5, "ready_wins");

    // addi stalled in EXEC and WB
    cyc(OP_ADD, 1'b0, 1'b0, E_FETCH, 32'd6, "st_fetch");
    cyc(OP_ADD, 1'b0, 1'b0, E_DEC, 32'd6, "st_dec");
    for (int i = 0; i < 5; i++)
      cyc(OP_BAD, 1'b1, 1'b1, E_EX_ADD, 32'd6, $sformatf("st_exec%0d", i));
    cyc(OP_BAD, 1'b0, 1'b0, E_EX_ADD, 32'd6, "st_exec_go");
    cyc(OP_BAD, 1'b1, 1'b0, E_WB_STALL, 32'd6, "st_wb_hold");
    cyc(OP_BAD, 1'b0, 1'b0, E_WB_I, 32'd6, "st_wb_go");

    // lw stalled in MEM, then reset mid-access
    cyc(OP_LW, 1'b0, 1'b0, E_FETCH, 32'd7, "rs_fetch");
    cyc(OP_LW, 1'b0, 1'b0, E_DEC, 32'd7, "rs_dec");
    cyc(OP_LW, 1'b0, 1'b0, E_EX_ADD, 32'd7, "rs_exec");
    cyc(OP_LW, 1'b0, 1'b0, E_MEM_LW, 32'd7, "rs_mem");
    cyc(OP_LW, 1'b1, 1'b1, E_MEM_STL, 32'd7, "rs_mem_stall_ready");
    cyc(OP_LW, 1'b1, 1'b0, E_MEM_STL, 32'd7, "rs_mem_stall_hold");
    cyc(OP_LW, 1'b0, 1'b0, E_MEM_LW, 32'd7, "rs_mem_resume");
    bus.stall = 1'b1;
    bus.mem_ready = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    chk(E_RST, 32'd0, "rs_async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(OP_LW, 1'b0, 1'b0, E_RST, 32'd0, "rs_after_release");
    cyc(OP_LW, 1'b0, 1'b0, E_FETCH, 32'd0, "rs_refetch");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
